// File: rtl/lsu_mem_master.sv
// lsu_mem_master: turns one MEM-stage load/store into one or two
// doubleword beats on the RAM data port, with extended load return.
module lsu_mem_master (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [63:0] write_mask,
  output logic [63:0] data_addr,
  output logic [63:0] write_data,
  input  logic [63:0] read_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    RESP = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] lo_q, lo_d;
  logic [63:0] rdata_q, rdata_d;

  logic [2:0]   off;
  logic [3:0]   nb;
  logic         split;
  logic [5:0]   sh;
  logic [63:0]  base;
  logic [63:0]  bmask;
  logic [127:0] s_lanes;
  logic [127:0] m_lanes;
  logic [127:0] rd_pair;
  logic [63:0]  rd_shift;
  logic [63:0]  ext;
  logic         sx;

  // Lane geometry of the latched request.
  always_comb begin
    off   = addr_q[2:0];
    nb    = 4'd1 << size_q;
    split = ({1'b0, off} + nb) > 4'd8;
    sh    = {off, 3'b000};
    base  = {addr_q[63:3], 3'b000};
    bmask = 64'd0;
    unique case (size_q)
      2'd0: bmask = 64'h0000_0000_0000_00FF;
      2'd1: bmask = 64'h0000_0000_0000_FFFF;
      2'd2: bmask = 64'h0000_0000_FFFF_FFFF;
      2'd3: bmask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    s_lanes = {64'd0, wdata_q} << sh;
    m_lanes = {64'd0, bmask} << sh;
  end

  // Load extraction; hi is the live beat in ACC1, zero otherwise.
  always_comb begin
    rd_pair  = (state_q == ACC1) ? {read_data, lo_q}
                                 : {64'd0, read_data};
    rd_shift = 64'(rd_pair >> sh);
    sx       = ~uns_q;
    ext      = rd_shift;
    unique case (size_q)
      2'd0: ext = {{56{sx & rd_shift[7]}}, rd_shift[7:0]};
      2'd1: ext = {{48{sx & rd_shift[15]}}, rd_shift[15:0]};
      2'd2: ext = {{32{sx & rd_shift[31]}}, rd_shift[31:0]};
      2'd3: ext = rd_shift;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      addr_q  <= 64'd0;
      wdata_q <= 64'd0;
      lo_q    <= 64'd0;
      rdata_q <= 64'd0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      lo_q    <= lo_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    lo_d    = lo_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = ACC0;
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
        end
      end
      ACC0: begin
        lo_d = read_data;
        if (split) begin
          state_d = ACC1;
        end else begin
          state_d = RESP;
          rdata_d = we_q ? 64'd0 : ext;
        end
      end
      ACC1: begin
        state_d = RESP;
        rdata_d = we_q ? 64'd0 : ext;
      end
      RESP: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == RESP);
    resp_rdata = rdata_q;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    write_mask = 64'd0;
    data_addr  = 64'd0;
    write_data = 64'd0;
    unique case (state_q)
      ACC0: begin
        data_addr = base;
        mem_read  = ~we_q;
        mem_write = we_q;
        if (we_q) begin
          write_mask = m_lanes[63:0];
          write_data = s_lanes[63:0];
        end
      end
      ACC1: begin
        data_addr = base + 64'd8;
        mem_read  = ~we_q;
        mem_write = we_q;
        if (we_q) begin
          write_mask = m_lanes[127:64];
          write_data = s_lanes[127:64];
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master: directed + random loads/stores against a
// byte-addressed reference memory and a 16-doubleword RAM model.
module tb_lsu_mem_master;

  localparam logic [63:0] BASE = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] write_mask;
  logic [63:0] data_addr;
  logic [63:0] write_data;
  logic [63:0] read_data;

  always #5 clk = ~clk;

  lsu_mem_master dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .write_mask   (write_mask),
    .data_addr    (data_addr),
    .write_data   (write_data),
    .read_data    (read_data)
  );

  logic [63:0] ram [0:15];
  logic [7:0]  ref_mem [0:127];

  assign read_data = ram[data_addr[6:3]];

  always @(posedge clk) begin
    if (mem_write)
      for (int b = 0; b < 8; b++)
        if (write_mask[8*b])
          ram[data_addr[6:3]][8*b +: 8] <= write_data[8*b +: 8];
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_load(input int a, input int nb,
                                             input logic uns);
    logic [63:0] v = '0;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[a+i];
    if (!uns && nb < 8 && v[8*nb-1])
      for (int j = nb; j < 8; j++) v[8*j +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [63:0] beat_mask(input int a, input int nb,
                                            input int b);
    logic [63:0] m = '0;
    for (int i = 0; i < nb; i++)
      if (((a+i) >> 3) == (a >> 3) + b) m[((a+i)%8)*8 +: 8] = 8'hFF;
    return m;
  endfunction

  function automatic logic [63:0] beat_data(input int a, input int nb,
                                            input logic [63:0] wd,
                                            input int b);
    logic [63:0] d = '0;
    for (int i = 0; i < nb; i++)
      if (((a+i) >> 3) == (a >> 3) + b)
        d[((a+i)%8)*8 +: 8] = wd[8*i +: 8];
    return d;
  endfunction

  logic [63:0] b_addr [0:3];
  logic [63:0] b_mask [0:3];
  logic [63:0] b_data [0:3];
  logic        b_rd   [0:3];
  logic        b_wr   [0:3];
  int          nbeat;
  int          lat;
  logic [63:0] got;

  task automatic drive(input logic we, input logic [1:0] sz,
                       input logic uns, input int a,
                       input logic [63:0] wd);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = BASE + 64'(a);
    req_wdata    = wd;
  endtask

  task automatic xact(input string tag, input logic we,
                      input logic [1:0] sz, input logic uns,
                      input int a, input logic [63:0] wd);
    int  nb;
    bit  split;
    int  eb;
    nb    = 1 << sz;
    split = (a % 8) + nb > 8;
    eb    = split ? 2 : 1;
    @(negedge clk);
    chk1({tag, ".ready"}, req_ready, 1'b1);
    drive(we, sz, uns, a, wd);
    @(posedge clk);
    #1 req_valid = 1'b0;
    nbeat = 0;
    lat   = 0;
    for (int k = 1; k <= 6 && lat == 0; k++) begin
      @(negedge clk);
      if (mem_read || mem_write) begin
        if (nbeat < 4) begin
          b_addr[nbeat] = data_addr;
          b_mask[nbeat] = write_mask;
          b_data[nbeat] = write_data;
          b_rd[nbeat]   = mem_read;
          b_wr[nbeat]   = mem_write;
        end
        nbeat++;
      end
      if (resp_valid) begin
        lat = k;
        got = resp_rdata;
      end
    end
    chk({tag, ".lat"}, 64'(lat), split ? 64'd3 : 64'd2);
    chk({tag, ".beats"}, 64'(nbeat), 64'(eb));
    for (int b = 0; b < eb && b < nbeat; b++) begin
      chk($sformatf("%s.addr%0d", tag, b), b_addr[b],
          BASE + 64'(((a >> 3) + b) * 8));
      chk1($sformatf("%s.rd%0d", tag, b), b_rd[b], ~we);
      chk1($sformatf("%s.wr%0d", tag, b), b_wr[b], we);
      chk($sformatf("%s.mask%0d", tag, b), b_mask[b],
          we ? beat_mask(a, nb, b) : 64'd0);
      chk($sformatf("%s.wdat%0d", tag, b), b_data[b],
          we ? beat_data(a, nb, wd, b) : 64'd0);
    end
    chk({tag, ".rdata"}, got, we ? 64'd0 : model_load(a, nb, uns));
    if (we)
      for (int i = 0; i < nb; i++) ref_mem[a+i] = wd[8*i +: 8];
  endtask

  initial begin
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_addr     = 64'd0;
    req_wdata    = 64'd0;
    for (int i = 0; i < 16; i++) begin
      ram[i] = {$urandom, $urandom};
      for (int b = 0; b < 8; b++) ref_mem[8*i+b] = ram[i][8*b +: 8];
    end
    #1;
    chk1("rst.ready", req_ready, 1'b1);
    chk1("rst.resp_valid", resp_valid, 1'b0);
    chk("rst.resp_rdata", resp_rdata, 64'd0);
    chk1("rst.mem_read", mem_read, 1'b0);
    chk1("rst.mem_write", mem_write, 1'b0);
    chk("rst.mask", write_mask, 64'd0);
    chk("rst.addr", data_addr, 64'd0);
    chk("rst.wdata", write_data, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    xact("sd", 1'b1, 2'd3, 1'b0, 16, 64'h1122334455667788);
    chk("sd.mask_const", b_mask[0], 64'hFFFF_FFFF_FFFF_FFFF);
    chk("sd.addr_const", b_addr[0], 64'h8000_0010);
    xact("ld", 1'b0, 2'd3, 1'b0, 16, 64'd0);
    chk("ld.const", got, 64'h1122334455667788);
    xact("lb", 1'b0, 2'd0, 1'b0, 16, 64'd0);
    chk("lb.const", got, 64'hFFFF_FFFF_FFFF_FF88);
    xact("lbu", 1'b0, 2'd0, 1'b1, 16, 64'd0);
    chk("lbu.const", got, 64'h88);
    xact("lb13", 1'b0, 2'd0, 1'b0, 19, 64'd0);
    chk("lb13.const", got, 64'h55);

    xact("sw", 1'b1, 2'd2, 1'b0, 22, 64'hAABBCCDD);
    chk("sw.mask0_const", b_mask[0], 64'hFFFF_0000_0000_0000);
    chk("sw.data0_const", b_data[0], 64'hCCDD_0000_0000_0000);
    chk("sw.mask1_const", b_mask[1], 64'h0000_0000_0000_FFFF);
    chk("sw.data1_const", b_data[1], 64'h0000_0000_0000_AABB);
    xact("lw", 1'b0, 2'd2, 1'b0, 22, 64'd0);
    chk("lw.const", got, 64'hFFFF_FFFF_AABB_CCDD);
    xact("lwu", 1'b0, 2'd2, 1'b1, 22, 64'd0);
    chk("lwu.const", got, 64'h0000_0000_AABB_CCDD);

    xact("sb17", 1'b1, 2'd0, 1'b0, 23, 64'h34);
    xact("sb18", 1'b1, 2'd0, 1'b0, 24, 64'h12);
    xact("lh17", 1'b0, 2'd1, 1'b0, 23, 64'd0);
    chk("lh17.const", got, 64'h1234);

    // Back-to-back with req_valid held; fields change mid-operation.
    @(negedge clk);
    drive(1'b0, 2'd3, 1'b0, 16, 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk1("hold.acc0_ready", req_ready, 1'b0);
    chk("hold.acc0_addr", data_addr, BASE + 64'h10);
    drive(1'b0, 2'd2, 1'b1, 64, 64'hDEAD);
    @(negedge clk);
    chk1("hold.resp_ready", req_ready, 1'b0);
    chk1("hold.resp_valid", resp_valid, 1'b1);
    chk("hold.a_rdata", resp_rdata, model_load(16, 8, 1'b0));
    @(negedge clk);
    chk1("hold.idle_ready", req_ready, 1'b1);
    chk1("hold.idle_resp", resp_valid, 1'b0);
    @(negedge clk);
    chk("hold.b_addr", data_addr, BASE + 64'h40);
    chk1("hold.b_read", mem_read, 1'b1);
    req_valid = 1'b0;
    @(negedge clk);
    chk1("hold.b_resp", resp_valid, 1'b1);
    chk("hold.b_rdata", resp_rdata, model_load(64, 4, 1'b1));

    // Reset during ACC1 of a split store.
    @(negedge clk);
    drive(1'b1, 2'd2, 1'b0, 22, 64'h11223344);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk1("rsw.acc0_wr", mem_write, 1'b1);
    @(posedge clk);
    #2;
    chk1("rsw.acc1_wr", mem_write, 1'b1);
    chk("rsw.acc1_addr", data_addr, BASE + 64'h18);
    rst = 1'b1;
    #1;
    chk1("rsw.wr_drop", mem_write, 1'b0);
    chk1("rsw.rd_drop", mem_read, 1'b0);
    chk("rsw.mask_drop", write_mask, 64'd0);
    chk("rsw.addr_drop", data_addr, 64'd0);
    chk("rsw.data_drop", write_data, 64'd0);
    chk1("rsw.no_resp", resp_valid, 1'b0);
    ref_mem[22] = 8'h44;
    ref_mem[23] = 8'h33;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk1("rsw.ready", req_ready, 1'b1);
    begin
      int seen = 0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (resp_valid) seen++;
      end
      chk("rsw.resp_count", 64'(seen), 64'd0);
    end
    xact("rsw.lh16", 1'b0, 2'd1, 1'b1, 22, 64'd0);
    chk("rsw.lh16_const", got, 64'h3344);
    xact("rsw.lh18", 1'b0, 2'd1, 1'b1, 24, 64'd0);
    chk("rsw.lh18_const", got, 64'hAA12);

    for (int n = 0; n < 80; n++) begin
      logic [1:0]  sz;
      logic [63:0] wd;
      int          a;
      sz = 2'($urandom_range(0, 3));
      a  = int'($urandom_range(0, 119));
      wd = {$urandom, $urandom};
      if (sz != 2'd3) wd = wd & ((64'd1 << (8 << sz)) - 64'd1);
      xact($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), sz,
           1'($urandom_range(0, 1)), a, wd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_mem_master.md
# lsu_mem_master

Load/store initiator that turns one pipeline memory request into accesses on the RAM model's 64-bit data port: `mem_read`, `mem_write`, `write_mask`, `data_addr`, `write_data` and `read_data`. It sits between the MEM stage and `ram_mem`. It aligns byte, half, word and double accesses to 8-byte beats and builds per-byte bit masks. Accesses that cross a doubleword boundary are split into two beats, and load results are returned sign- or zero-extended through a one-cycle response pulse.

## Interface
Parameters:
- none (data width fixed at 64; addresses are physical, the RAM applies the 0x8000_0000 base)

Ports:
- clk  in  1  single clock; everything updates on posedge
- rst  in  1  reset, asynchronous and active-high
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 = B, 01 = H, 10 = W, 11 = D
- req_unsigned  in  1  zero-extend a load; ignored for stores and for size D
- req_addr  in  64  byte address, any alignment
- req_wdata  in  64  store data, right-justified
- resp_valid  out  1  one-cycle pulse when the request completes (loads and stores)
- resp_rdata  out  64  extended load data; 0 for stores
- mem_read  out  1  RAM read enable
- mem_write  out  1  RAM write enable; the write commits at the posedge ending the cycle
- write_mask  out  64  bit mask, 0xFF per enabled byte
- data_addr  out  64  doubleword-aligned byte address (bits [2:0] = 0)
- write_data  out  64  lane-shifted store data
- read_data  in  64  combinational RAM read data, valid in the same cycle as `data_addr`

## Operation
- States: IDLE, ACC0, ACC1, RESP.
- Let off = req_addr[2:0] and nb = 1, 2, 4 or 8 bytes by size.
- A request is split when off + nb > 8. B never splits; H splits at off 7; W at off 5–7; D at off 1–7.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid`, latch we, size, unsigned, addr and wdata, then go to ACC0.
- ACC0:
  - `data_addr` = {addr[63:3], 3'b000}.
  - `mem_read` = !we, `mem_write` = we.
  - Store lanes: form the 128-bit values S = wdata << (8·off) and M = bytemask(nb) << (8·off). Drive `write_data` = S[63:0] and `write_mask` = M[63:0].
  - Load: capture `read_data` into lo.
  - Split → ACC1; otherwise → RESP.
- ACC1:
  - `data_addr` = ({addr[63:3], 3'b000} + 8), modulo 2^64.
  - `write_data` = S[127:64], `write_mask` = M[127:64].
  - Load: capture `read_data` as hi (hi = 0 for a non-split access).
  - Next state RESP.
- Load result:
  - Compute ({hi, lo} >> 8·off)[8·nb-1:0].
  - Sign-extend from bit 8·nb-1 unless unsigned or D.
  - Register into `resp_rdata` at the end of the last access cycle.
- RESP:
  - `resp_valid` = 1 for exactly one cycle.
  - Next state IDLE.
- Outside ACC0/ACC1, `mem_read`, `mem_write`, `write_mask`, `data_addr` and `write_data` are all 0.
- `req_valid` while not in IDLE is ignored. No queueing; the requester holds its request.
- Write masks never enable bytes outside the request. A split store writes beat 0 in ACC0 and beat 1 in ACC1.

## Timing
- Reset: state = IDLE.
  - `req_ready` = 1.
  - `resp_valid` = 0, `resp_rdata` = 0.
  - All memory outputs = 0.
  - Reset takes effect immediately (asynchronous), mid-operation included.
- Reset during ACC1 of a split store: beat 0 has already committed; beat 1 is abandoned; no `resp_valid`.
- Latency, counted from the acceptance edge (posedge with `req_valid` & `req_ready`) to the `resp_valid` cycle:
  - aligned access: ACC0 then RESP, so `resp_valid` is high in the 2nd cycle after acceptance;
  - split access: 3rd cycle.
- Throughput: one request per 3 cycles aligned, per 4 cycles split (RESP → IDLE → accept).
- `req_ready` is combinational from state. `resp_rdata` holds its value until the next RESP.

## Test plan
- SD 0x1122334455667788 @0x8000_0010:
  - one ACC cycle with `mem_write` = 1, `data_addr` = 0x8000_0010, `write_mask` = all ones;
  - a following LD returns the same value, with `resp_valid` 2 cycles after acceptance.
- LB @0x8000_0010 after that SD → 0xFFFF_FFFF_FFFF_FF88; LBU → 0x0000_0000_0000_0088; LB @0x8000_0013 → 0x55.
- SW 0xAABBCCDD @0x8000_0016 (split):
  - beat 0: `data_addr` 0x8000_0010, `write_mask` 0xFFFF_0000_0000_0000, `write_data` 0xCCDD_0000_0000_0000;
  - beat 1: `data_addr` 0x8000_0018, `write_mask` 0x0000_0000_0000_FFFF, `write_data` 0x0000_0000_0000_AABB;
  - LW @0x8000_0016 → 0xFFFF_FFFF_AABB_CCDD, `resp_valid` 3 cycles after acceptance; LWU → 0x0000_0000_AABB_CCDD.
- LH @0x8000_0017 with bytes 0x34 @..17 and 0x12 @..18 → two read beats, result 0x0000_0000_0000_1234.
- `req_valid` held high across two requests → `req_ready` = 0 from ACC0 through RESP; the second request is accepted only in the next IDLE cycle; its latched fields are unaffected by mid-operation input changes.
- `rst` pulsed during ACC1 of the split store above:
  - all memory outputs drop to 0 without a clock edge;
  - the bytes @0x8000_0016–17 are written, those @0x8000_0018–19 are unchanged;
  - no `resp_valid`; `req_ready` = 1 after `rst` deasserts.
